pattern_scheduler: RTL

- Sequences which test-pattern generator drives the VGA pixel path.
- Takes NUM_SRC packed 30-bit RGB sources and steps through them, in manual mode on a pushbutton and in auto mode on a frame-count dwell.
- A new source is committed only at a frame boundary, optionally after GAP_FRAMES of black.
- Sits between the pattern generators and vga_sync's iRGB input, clocked by the VGA control clock.

---
 rtl/pattern_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pattern_scheduler.sv
// pattern_scheduler
//   Chooses which of NUM_SRC test-pattern generators drives the VGA pixel
//   path. Sources advance on a debounced pushbutton (manual) or after a
//   fixed number of frames (auto). A change only takes effect at the start
//   of vsync, optionally after GAP_FRAMES of black.
//
// Ports
//   iCLK     VGA control clock
//   iRST_N   asynchronous active-low reset
//   iRGB     packed sources, source k at [30k+29:30k]
//   iVS      vsync from vga_sync, active-low, already in iCLK domain
//   iNEXT_N  raw pushbutton, active-low, asynchronous
//   iAUTO    raw mode switch (1 = auto), asynchronous
//   oRGB     selected source, or black during a gap
//   oSEL     index of the source currently displayed
//   oGAP     high while black gap frames are shown
//   oSWITCH  one-cycle pulse on the cycle oSEL changes
module pattern_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int SEL_W        = 2,
  parameter int DWELL_FRAMES = 120,
  parameter int GAP_FRAMES   = 1,
  parameter int DB_CYCLES    = 250000
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic [30*NUM_SRC-1:0] iRGB,
  input  logic                  iVS,
  input  logic                  iNEXT_N,
  input  logic                  iAUTO,
  output logic [29:0]           oRGB,
  output logic [SEL_W-1:0]      oSEL,
  output logic                  oGAP,
  output logic                  oSWITCH
);

  localparam int DW = $clog2(DWELL_FRAMES) + 1;
  localparam int GW = $clog2(GAP_FRAMES + 1) + 1;
  localparam int CW = $clog2(DB_CYCLES);

  localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL_FRAMES - 1);
  localparam logic [GW-1:0]    GAP_INIT   = GW'(GAP_FRAMES);
  localparam logic [CW-1:0]    DB_LAST    = CW'(DB_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_SRC - 1);

  typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;

  // Input conditioning
  logic          next_s1, next_s2;
  logic          auto_s1, auto_s2, auto_q;
  logic          db_level, db_q;
  logic [CW-1:0] db_cnt;
  logic          vs_q;

  logic press;
  logic tick;
  logic mode_chg;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      next_s1  <= 1'b1;
      next_s2  <= 1'b1;
      auto_s1  <= 1'b0;
      auto_s2  <= 1'b0;
      auto_q   <= 1'b0;
      db_level <= 1'b1;
      db_q     <= 1'b1;
      db_cnt   <= '0;
      vs_q     <= 1'b0;
    end else begin
      next_s1 <= iNEXT_N;
      next_s2 <= next_s1;
      auto_s1 <= iAUTO;
      auto_s2 <= auto_s1;
      auto_q  <= auto_s2;
      vs_q    <= iVS;
      db_q    <= db_level;
      // The counter only runs while the synchronized button disagrees with
      // the debounced level; any return to the old level restarts it.
      if (next_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= next_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  assign press    = db_q & ~db_level;
  assign tick     = vs_q & ~iVS;
  assign mode_chg = auto_s2 ^ auto_q;

  // Scheduler
  state_t        state;
  logic          pending;
  logic [DW-1:0] dwell_cnt;
  logic [GW-1:0] gap_cnt;

  logic [SEL_W-1:0] next_sel;
  logic             auto_due;
  logic             advance;

  always_comb begin
    next_sel = (oSEL == SEL_LAST) ? '0 : oSEL + SEL_W'(1);
    auto_due = auto_s2 && (dwell_cnt == DWELL_LAST);
    advance  = pending || auto_due;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= SHOW;
      oSEL      <= '0;
      oGAP      <= 1'b0;
      oSWITCH   <= 1'b0;
      pending   <= 1'b0;
      dwell_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      oSWITCH <= 1'b0;
      case (state)
        SHOW: begin
          if (mode_chg) begin
            pending   <= 1'b0;
            dwell_cnt <= '0;
          end else if (tick) begin
            if (auto_s2) begin
              dwell_cnt <= auto_due ? '0 : dwell_cnt + DW'(1);
            end
            // A press landing on a tick belongs to the next frame boundary.
            pending <= press && !auto_s2;
            if (advance) begin
              if (GAP_FRAMES == 0) begin
                oSEL    <= next_sel;
                oSWITCH <= 1'b1;
              end else begin
                state   <= GAP;
                gap_cnt <= GAP_INIT;
                oGAP    <= 1'b1;
                pending <= 1'b0;
              end
            end
          end else if (press && !auto_s2) begin
            pending <= 1'b1;
          end
        end
        GAP: begin
          pending   <= 1'b0;
          dwell_cnt <= '0;
          if (tick) begin
            gap_cnt <= gap_cnt - GW'(1);
            if (gap_cnt == GW'(1)) begin
              state   <= SHOW;
              oSEL    <= next_sel;
              oGAP    <= 1'b0;
              oSWITCH <= 1'b1;
            end
          end
        end
        default: state <= SHOW;
      endcase
    end
  end

  // Zero-latency pixel mux straight from the registered select.
  always_comb begin
    oRGB = '0;
    if (!oGAP) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (oSEL == SEL_W'(k)) oRGB = iRGB[30*k +: 30];
      end
    end
  end

endmodule
